waveform_seq_gen: RTL and testbench

Parametrised multi-channel waveform sequencer for the waveform test programs. On a start pulse it runs a bounded sequence. Each channel toggles over a programmable window of cycles from a programmable initial level. An optional half-cycle (negedge) delay can be applied per channel. A window/marker output is set and cleared at programmable counts, and a start/busy/done handshake lets a testbench or controller chain runs.

---
 rtl/waveform_seq_gen_if.sv | 25 ++
 rtl/waveform_seq_gen.sv | 97 +++++++++
 tb/tb_waveform_seq_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/waveform_seq_gen_if.sv
// waveform_seq_gen_if: control, config and waveform outputs of the sequencer
interface waveform_seq_gen_if #(parameter int NCH = 4, parameter int CW = 8);
  logic              start;
  logic              abort;
  logic [CW-1:0]     run_len;
  logic [NCH*CW-1:0] ch_start;
  logic [NCH*CW-1:0] ch_len;
  logic [NCH-1:0]    ch_init;
  logic [NCH-1:0]    ch_neg;
  logic [CW-1:0]     win_set;
  logic [CW-1:0]     win_clr;
  logic [NCH-1:0]    wave;
  logic              win;
  logic              busy;
  logic              done;
  logic [CW-1:0]     cnt;
  modport master (
    output start, abort, run_len, ch_start, ch_len, ch_init, ch_neg, win_set, win_clr,
    input  wave, win, busy, done, cnt
  );
  modport slave (
    input  start, abort, run_len, ch_start, ch_len, ch_init, ch_neg, win_set, win_clr,
    output wave, win, busy, done, cnt
  );
endinterface

// File: rtl/waveform_seq_gen.sv
// waveform_seq_gen: multi-channel toggle-window sequencer with window marker and negedge channel stage
module waveform_seq_gen #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input logic clk,
  input logic rst,
  waveform_seq_gen_if.slave b
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, len_q, len_d, set_q, set_d, clr_q, clr_d;
  logic [NCH*CW-1:0] cs_q, cs_d, cl_q, cl_d;
  logic [NCH-1:0]    init_q, init_d, neg_q, neg_d, wave_p_q, wave_p_d, wave_n_q, tog;
  logic              win_q, win_d, last, accept;
  // window end is formed one bit wider so start+len never wraps back below start
  for (genvar i = 0; i < NCH; i++) begin : g_tog
    assign tog[i] = ({1'b0, cnt_q} >= {1'b0, cs_q[i*CW +: CW]}) &&
                    ({1'b0, cnt_q} < ({1'b0, cs_q[i*CW +: CW]} + {1'b0, cl_q[i*CW +: CW]}));
  end
  assign last   = cnt_q == len_q - CW'(1);
  assign accept = state_q == IDLE && b.start && !b.abort;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    set_d    = set_q;
    clr_d    = clr_q;
    cs_d     = cs_q;
    cl_d     = cl_q;
    init_d   = init_q;
    neg_d    = neg_q;
    wave_p_d = wave_p_q;
    win_d    = win_q;
    if (b.abort) begin
      state_d  = IDLE;
      cnt_d    = '0;
      wave_p_d = init_q;
      win_d    = 1'b0;
    end else if (accept) begin
      state_d  = RUN;
      cnt_d    = '0;
      len_d    = b.run_len == '0 ? CW'(1) : b.run_len;
      set_d    = b.win_set;
      clr_d    = b.win_clr;
      cs_d     = b.ch_start;
      cl_d     = b.ch_len;
      init_d   = b.ch_init;
      neg_d    = b.ch_neg;
      wave_p_d = b.ch_init;
      win_d    = 1'b0;
    end else if (state_q == RUN) begin
      wave_p_d = wave_p_q ^ tog;
      win_d    = cnt_q == clr_q ? 1'b0 : cnt_q == set_q ? 1'b1 : win_q;
      state_d  = last ? DONE : RUN;
      cnt_d    = last ? cnt_q : cnt_q + CW'(1);
    end else if (state_q == DONE) begin
      state_d  = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      set_q    <= '0;
      clr_q    <= '0;
      cs_q     <= '0;
      cl_q     <= '0;
      init_q   <= '0;
      neg_q    <= '0;
      wave_p_q <= '0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      set_q    <= set_d;
      clr_q    <= clr_d;
      cs_q     <= cs_d;
      cl_q     <= cl_d;
      init_q   <= init_d;
      neg_q    <= neg_d;
      wave_p_q <= wave_p_d;
      win_q    <= win_d;
    end
  end
  always_ff @(negedge clk) begin
    if (rst) wave_n_q <= '0;
    else     wave_n_q <= wave_p_q;
  end
  assign b.wave = (neg_q & wave_n_q) | (~neg_q & wave_p_q);
  assign b.win  = win_q;
  assign b.busy = state_q == RUN;
  assign b.done = state_q == DONE;
  assign b.cnt  = cnt_q;
endmodule

// File: tb/tb_waveform_seq_gen.sv
// tb_waveform_seq_gen: table-driven vectors plus directed multi-cycle sequences for waveform_seq_gen
module tb_waveform_seq_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  waveform_seq_gen_if #(.NCH(4), .CW(8)) bus ();
  waveform_seq_gen #(.NCH(4), .CW(8)) dut (.clk(clk), .rst(rst), .b(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0]  run_len;
    logic [31:0] cs;
    logic [31:0] cl;
    logic [3:0]  init;
    logic [3:0]  neg;
    logic [7:0]  ws;
    logic [7:0]  wc;
    logic [3:0]  ew;
    logic        ewin;
    int          ecyc;
  } vec_t;
  vec_t vecs [6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cfg(input vec_t v);
    bus.run_len  = v.run_len;
    bus.ch_start = v.cs;
    bus.ch_len   = v.cl;
    bus.ch_init  = v.init;
    bus.ch_neg   = v.neg;
    bus.win_set  = v.ws;
    bus.win_clr  = v.wc;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_cnt(input logic [7:0] target);
    int n = 0;
    while (bus.cnt !== target && n < 300) begin
      tick();
      n++;
    end
    chk("wait_cnt", {24'd0, bus.cnt}, {24'd0, target});
  endtask
  task automatic run_vec(input int idx);
    int n = 0;
    cfg(vecs[idx]);
    pulse_start();
    chk($sformatf("v%0d busy_at_start", idx), {31'd0, bus.busy}, 32'd1);
    chk($sformatf("v%0d cnt_at_start", idx), {24'd0, bus.cnt}, 32'd0);
    while (bus.busy === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    chk($sformatf("v%0d busy_cycles", idx), n, vecs[idx].ecyc);
    chk($sformatf("v%0d done", idx), {31'd0, bus.done}, 32'd1);
    chk($sformatf("v%0d win_final", idx), {31'd0, bus.win}, {31'd0, vecs[idx].ewin});
    tick();
    chk($sformatf("v%0d done_cleared", idx), {31'd0, bus.done}, 32'd0);
    chk($sformatf("v%0d wave_final", idx), {28'd0, bus.wave}, {28'd0, vecs[idx].ew});
  endtask
  function automatic logic [3:0] expw(input int k);
    logic [3:0] r;
    r = 4'b0101;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < k; c++)
        if (c >= i && c < i + 10) r[i] = ~r[i];
    return r;
  endfunction
  task automatic trace(input logic [3:0] neg);
    vec_t v;
    logic [3:0] e, ep;
    v = vecs[0];
    v.neg = neg;
    cfg(v);
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      e = expw(k);
      chk($sformatf("trace cnt k=%0d", k), {24'd0, bus.cnt}, k);
      chk($sformatf("trace win k=%0d", k), {31'd0, bus.win}, {31'd0, (k >= 5 && k <= 8)});
      if (k == 0) chk("trace pos wave k=0", {28'd0, bus.wave & ~neg}, {28'd0, e & ~neg});
      else begin
        ep = (e & ~neg) | (expw(k - 1) & neg);
        chk($sformatf("trace pos wave neg=%b k=%0d", neg, k), {28'd0, bus.wave}, {28'd0, ep});
      end
      #5;
      chk($sformatf("trace neg-half wave neg=%b k=%0d", neg, k), {28'd0, bus.wave}, {28'd0, e});
      #5;
    end
    chk("trace done", {31'd0, bus.done}, 32'd1);
    chk("trace cnt_hold", {24'd0, bus.cnt}, 32'd11);
    tick();
  endtask
  initial begin
    vecs[0] = '{8'd12,  32'h03020100, 32'h0a0a0a0a, 4'b0101, 4'b0000, 8'd4,   8'd8, 4'b1101, 1'b0, 12};
    vecs[1] = '{8'd0,   32'hfafafafa, 32'h0a0a0a0a, 4'b0011, 4'b0000, 8'd0,   8'd5, 4'b0011, 1'b1, 1};
    vecs[2] = '{8'd12,  32'h03020100, 32'h0a0a0a0a, 4'b0101, 4'b0000, 8'd6,   8'd6, 4'b1101, 1'b0, 12};
    vecs[3] = '{8'd5,   32'h00000000, 32'h00010203, 4'b0000, 4'b0000, 8'd2,   8'd9, 4'b0101, 1'b1, 5};
    vecs[4] = '{8'd8,   32'h06040200, 32'h05050505, 4'b1111, 4'b1010, 8'd7,   8'd3, 4'b1100, 1'b1, 8};
    vecs[5] = '{8'd255, 32'hf0f0f0f0, 32'h20202020, 4'b0000, 4'b0000, 8'd254, 8'd0, 4'b1111, 1'b1, 255};
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cfg(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("reset wave", {28'd0, bus.wave}, 32'd0);
    chk("reset win", {31'd0, bus.win}, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset cnt", {24'd0, bus.cnt}, 32'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) run_vec(i);
    trace(4'b0000);
    trace(4'b1010);
    // reset in the middle of a run
    cfg(vecs[0]);
    pulse_start();
    wait_cnt(8'd5);
    chk("rst pre win", {31'd0, bus.win}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst wave", {28'd0, bus.wave}, 32'd0);
    chk("rst win", {31'd0, bus.win}, 32'd0);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst cnt", {24'd0, bus.cnt}, 32'd0);
    run_vec(0);
    // abort at cnt 3
    cfg(vecs[0]);
    pulse_start();
    wait_cnt(8'd3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort wave", {28'd0, bus.wave}, 32'd5);
    chk("abort cnt", {24'd0, bus.cnt}, 32'd0);
    chk("abort win", {31'd0, bus.win}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    tick();
    chk("abort no_done", {31'd0, bus.done}, 32'd0);
    // start together with abort in IDLE does not launch a run
    bus.abort = 1'b1;
    pulse_start();
    bus.abort = 1'b0;
    chk("start_abort busy", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("start_abort busy2", {31'd0, bus.busy}, 32'd0);
    // start and config change during RUN and start during DONE are ignored
    begin
      int n = 0;
      cfg(vecs[0]);
      pulse_start();
      wait_cnt(8'd4);
      bus.run_len = 8'd3;
      bus.ch_init = 4'b1111;
      pulse_start();
      while (bus.busy === 1'b1 && n < 100) begin
        n++;
        tick();
      end
      chk("midrun remaining_cycles", n, 7);
      chk("midrun cnt_final", {24'd0, bus.cnt}, 32'd11);
      chk("midrun done", {31'd0, bus.done}, 32'd1);
      chk("midrun wave", {28'd0, bus.wave}, 32'hd);
      pulse_start();
      chk("start_in_done busy", {31'd0, bus.busy}, 32'd0);
      chk("start_in_done done", {31'd0, bus.done}, 32'd0);
      pulse_start();
      chk("restart after done", {31'd0, bus.busy}, 32'd1);
      chk("restart init", {28'd0, bus.wave}, 32'hf);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
